// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_arith_pkg;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor_gate.sv
// rtl/full_subtractor_gate.sv - single-bit full subtractor built from basic gates
module full_subtractor_gate (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    logic a_xor_b;
    logic borrow_gen;
    logic borrow_prop;

    assign a_xor_b     = A ^ B;
    assign Diff        = a_xor_b ^ Bin;
    assign borrow_gen  = ~A & B;
    assign borrow_prop = ~a_xor_b & Bin;
    assign Bout        = borrow_gen | borrow_prop;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] res_shifted;

    full_subtractor_gate u_cell (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Bin  (bor_q),
        .Diff (cell_diff),
        .Bout (cell_bout)
    );

    // The partial result keeps only WIDTH-1 bits; the last cell output completes it on the DONE load.
    assign res_shifted = {cell_diff, res_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bor_d    = bor_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shifted[WIDTH-1:1];
                bor_d = cell_bout;
                if (cnt_q == CNT_LAST) begin
                    diff_d   = res_shifted;
                    borrow_d = cell_bout;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bor_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bor_q    <= bor_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH 8 and 16
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8, diff8;
    logic [15:0] a16, b16, diff16;
    logic        busy8, done8, borrow8;
    logic        busy16, done16, borrow16;

    int n_vec  = 0;
    int n_fail = 0;
    int done_cnt8 = 0;

    logic [8:0]  exp8[$];
    logic [16:0] exp16[$];
    logic [8:0]  last8, cur8;
    logic [16:0] last16, cur16;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .Start(start8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .Diff(diff8), .Borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .Start(start16), .A(a16), .B(b16),
        .Busy(busy16), .Done(done16), .Diff(diff16), .Borrow(borrow16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            if (exp8.size() == 0) begin
                check("unexpected_done8", 32'(done8), 32'd0);
            end else begin
                automatic logic [8:0] e = exp8.pop_front();
                check("diff8", 32'(diff8), 32'(e[7:0]));
                check("borrow8", 32'(borrow8), 32'(e[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            if (exp16.size() == 0) begin
                check("unexpected_done16", 32'(done16), 32'd0);
            end else begin
                automatic logic [16:0] e = exp16.pop_front();
                check("diff16", 32'(diff16), 32'(e[15:0]));
                check("borrow16", 32'(borrow16), 32'(e[16]));
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = a; b8 = b;
        cur8 = {1'b0, a} - {1'b0, b};
        exp8.push_back(cur8);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait_done8();
        int  cyc  = 0;
        bit  seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                seen = 1;
            end else begin
                check("busy8", 32'(busy8), 32'd1);
                check("hold8", 32'({borrow8, diff8}), 32'(last8));
                start8 = 1'($urandom);
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        check("latency8", 32'(cyc), 32'd9);
        if (seen) last8 = cur8;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        start16 = 1'b1; a16 = a; b16 = b;
        cur16 = {1'b0, a} - {1'b0, b};
        exp16.push_back(cur16);
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    endtask

    task automatic wait_done16();
        int  cyc  = 0;
        bit  seen = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done16) begin
                seen = 1;
            end else begin
                check("busy16", 32'(busy16), 32'd1);
                check("hold16", 32'({borrow16, diff16}), 32'(last16));
                start16 = 1'($urandom);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
            end
        end
        start16 = 1'b0;
        check("latency16", 32'(cyc), 32'd17);
        if (seen) last16 = cur16;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        last8 = '0; last16 = '0; cur8 = '0; cur16 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_diff8", 32'(diff8), 32'd0);
        check("rst_borrow8", 32'(borrow8), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_diff16", 32'(diff16), 32'd0);

        issue8(8'd10, 8'd3);     wait_done8();
        issue8(8'd3, 8'd10);     wait_done8();
        issue8(8'd0, 8'd1);      wait_done8();
        issue8(8'hFF, 8'hFF);    wait_done8();
        issue16(16'd0, 16'd1);   wait_done16();
        issue16(16'hFFFF, 16'h0001); wait_done16();

        // Start held high: acceptances every WIDTH+2 cycles; A is disturbed only inside SHIFT.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
        repeat (3) exp8.push_back({1'b0, 8'd100});
        base = done_cnt8;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            a8 = (i % 10 >= 1 && i % 10 <= 5) ? 8'($urandom) : 8'd200;
        end
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("held_start_done_count", 32'(done_cnt8 - base), 32'd3);
        check("held_start_queue_empty", 32'(exp8.size()), 32'd0);
        last8 = {1'b0, 8'd100};

        // Reset on the fourth SHIFT cycle aborts with no Done pulse.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd77; b8 = 8'd5;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_diff8", 32'(diff8), 32'd0);
        check("abort_borrow8", 32'(borrow8), 32'd0);
        last8 = '0; last16 = '0;
        exp16.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done8", 32'(done8), 32'd0);
        end
        issue8(8'd55, 8'd66);  wait_done8();

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    automatic int r = $urandom_range(0, 5);
                    automatic logic [7:0] a = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
                    automatic logic [7:0] b = (r == 2) ? 8'h00 : (r == 3) ? 8'hFF : 8'($urandom);
                    issue8(a, b);
                    wait_done8();
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    issue16(pick16(), pick16());
                    wait_done16();
                end
            end
        join

        repeat (4) @(negedge clk);
        check("final_queue8_empty", 32'(exp8.size()), 32'd0);
        check("final_queue16_empty", 32'(exp16.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
